// File: rtl/glb_iact_pkg.sv
// Shared GLB iact constants: CSC word layout, terminator/pad words, encoder states.
// The PE-side decoder imports the same words and skips CSC_PAD_WORD.
package glb_iact_pkg;

  localparam int IACT_DATA_W = 8;
  localparam int IACT_CNT_W  = 4;
  localparam int IACT_NZ_W   = 11;
  localparam int CSC_W       = IACT_DATA_W + IACT_CNT_W;

  localparam logic [CSC_W-1:0] CSC_TERM_WORD = 12'h000;
  localparam logic [CSC_W-1:0] CSC_PAD_WORD  = 12'h00F;

  typedef enum logic [1:0] {
    S_PASS,
    S_PAD,
    S_TERM1,
    S_TERM2
  } enc_state_e;

endpackage

// File: rtl/iact_csc_encoder_if.sv
// Dense-in / CSC-out stream bundle of the iact encoder.
// slave = encoder side, master = producer/SRAM side.
interface iact_csc_encoder_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    in_col_last;
  logic                    in_mat_last;
  logic                    in_pass_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W+CNT_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_col_last,
    input  in_mat_last, in_pass_last, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_col_last,
    output in_mat_last, in_pass_last, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/csc_out_slot.sv
// Single-entry valid/ready output register with load/hold.
// Caller must only assert load while free is high.
module csc_out_slot #(
  parameter int W = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         free
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign free = ~valid_q | out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (free) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/iact_csc_encoder.sv
// Dense iact -> CSC {value,row} encoder, zero-dropping, with
// per-matrix and per-pass zero-word terminators.
import glb_iact_pkg::*;

module iact_csc_encoder #(
  parameter int DATA_W = IACT_DATA_W,
  parameter int CNT_W  = IACT_CNT_W,
  parameter int NZ_W   = IACT_NZ_W
) (
  input  logic            clock,
  input  logic            reset,
  iact_csc_encoder_if.slave bus,
  output logic            busy,
  output logic [NZ_W-1:0] nz_count,
  output logic            overflow
);

  localparam int W = DATA_W + CNT_W;

  enc_state_e       state_q, state_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [NZ_W-1:0]  nz_q, nz_d;
  logic             ovf_q, ovf_d;
  logic             pl_q, pl_d;

  logic             free, load, acc;
  logic             slot_valid;
  logic [W-1:0]     load_data, slot_data;

  assign bus.in_ready = (state_q == S_PASS) & free;
  assign acc          = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    nz_d      = nz_q;
    ovf_d     = ovf_q;
    pl_d      = pl_q;
    load      = 1'b0;
    load_data = '0;
    unique case (state_q)
      S_PASS: begin
        if (acc) begin
          if (bus.in_col_last) begin
            row_d = '0;
          end else begin
            row_d = row_q + 1'b1;
            if (row_q == '1) ovf_d = 1'b1;
          end
          if (bus.in_data != '0) begin
            load      = 1'b1;
            load_data = {bus.in_data, row_q};
            nz_d      = nz_q + 1'b1;
          end
          // empty matrix needs a pad so its terminator isn't read as write-done
          if (bus.in_mat_last) begin
            pl_d    = bus.in_pass_last;
            state_d = (nz_q == '0 && bus.in_data == '0) ? S_PAD : S_TERM1;
          end
        end
      end
      S_PAD: begin
        if (free) begin
          load      = 1'b1;
          load_data = W'(CSC_PAD_WORD);
          state_d   = S_TERM1;
        end
      end
      S_TERM1: begin
        if (free) begin
          load      = 1'b1;
          load_data = W'(CSC_TERM_WORD);
          nz_d      = '0;
          state_d   = pl_q ? S_TERM2 : S_PASS;
        end
      end
      S_TERM2: begin
        if (free) begin
          load      = 1'b1;
          load_data = W'(CSC_TERM_WORD);
          pl_d      = 1'b0;
          state_d   = S_PASS;
        end
      end
      default: state_d = S_PASS;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_PASS;
      row_q   <= '0;
      nz_q    <= '0;
      ovf_q   <= 1'b0;
      pl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      nz_q    <= nz_d;
      ovf_q   <= ovf_d;
      pl_q    <= pl_d;
    end
  end

  csc_out_slot #(.W(W)) u_slot (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .out_ready (bus.out_ready),
    .out_valid (slot_valid),
    .out_data  (slot_data),
    .free      (free)
  );

  assign bus.out_valid = slot_valid;
  assign bus.out_data  = slot_data;
  assign busy          = (state_q != S_PASS) | slot_valid;
  assign nz_count      = nz_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_iact_csc_encoder.sv
// Scoreboard bench for iact_csc_encoder: directed matrices,
// expected CSC words queued at issue, popped by a monitor.
module tb_iact_csc_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [10:0] nz_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  iact_csc_encoder_if bus ();

  iact_csc_encoder dut (
    .clock    (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .nz_count (nz_count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_word unexpected got %h", bus.out_data);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          errors++;
          $display("FAIL out_word got %h exp %h", bus.out_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic cl,
                      input logic ml, input logic pl);
    bus.in_valid     = 1'b1;
    bus.in_data      = d;
    bus.in_col_last  = cl;
    bus.in_mat_last  = ml;
    bus.in_pass_last = pl;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout data %h", d);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !busy) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout left %0d busy %0b", exp_q.size(), busy);
  endtask

  initial begin
    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_col_last  = 1'b0;
    bus.in_mat_last  = 1'b0;
    bus.in_pass_last = 1'b0;
    bus.out_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_nz", 32'(nz_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // col0=[0,5,0] col1=[7,0,0], end of pass
    exp_q.push_back(12'h051);
    exp_q.push_back(12'h070);
    exp_q.push_back(12'h000);
    exp_q.push_back(12'h000);
    send(8'h00, 0, 0, 0);
    send(8'h05, 0, 0, 0);
    chk("t1_nz1", 32'(nz_count), 1);
    send(8'h00, 1, 0, 0);
    send(8'h07, 0, 0, 0);
    send(8'h00, 0, 0, 0);
    send(8'h00, 1, 1, 1);
    chk("t1_nz2", 32'(nz_count), 2);
    drain();
    chk("t1_nz_clr", 32'(nz_count), 0);

    // [3,0] then [0,9] with pass_last on the second
    exp_q.push_back(12'h030);
    exp_q.push_back(12'h000);
    exp_q.push_back(12'h091);
    exp_q.push_back(12'h000);
    exp_q.push_back(12'h000);
    send(8'h03, 0, 0, 0);
    send(8'h00, 1, 1, 0);
    send(8'h00, 0, 0, 0);
    send(8'h09, 1, 1, 1);
    drain();

    // all-zero matrix gets a pad before its terminator
    exp_q.push_back(12'h00F);
    exp_q.push_back(12'h000);
    send(8'h00, 0, 0, 0);
    send(8'h00, 0, 0, 0);
    send(8'h00, 1, 1, 0);
    drain();

    // same matrix as first, stalled 5 cycles after first nonzero
    exp_q.push_back(12'h051);
    exp_q.push_back(12'h070);
    exp_q.push_back(12'h000);
    exp_q.push_back(12'h000);
    send(8'h00, 0, 0, 0);
    send(8'h05, 0, 0, 0);
    bus.out_ready    = 1'b0;
    bus.in_valid     = 1'b1;
    bus.in_data      = 8'h00;
    bus.in_col_last  = 1'b1;
    bus.in_mat_last  = 1'b0;
    bus.in_pass_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 0);
      chk("stall_out_valid", 32'(bus.out_valid), 1);
      chk("stall_out_data", 32'(bus.out_data), 32'h051);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(8'h00, 1, 0, 0);
    send(8'h07, 0, 0, 0);
    send(8'h00, 0, 0, 0);
    send(8'h00, 1, 1, 1);
    drain();

    // 17 nonzeros in one column: row wraps, overflow sticks
    for (int i = 1; i <= 16; i++)
      exp_q.push_back({8'(i), 4'(i - 1)});
    exp_q.push_back(12'h110);
    exp_q.push_back(12'h000);
    for (int i = 1; i <= 17; i++) begin
      send(8'(i), i == 17, i == 17, 0);
      if (i == 15) chk("ovf_before", 32'(overflow), 0);
      if (i == 16) chk("ovf_set", 32'(overflow), 1);
    end
    chk("ovf_nz17", 32'(nz_count), 17);
    drain();
    chk("ovf_sticky", 32'(overflow), 1);

    // reset while stalled in S_TERM1 with a word pending
    bus.out_ready = 1'b0;
    send(8'h21, 1, 1, 0);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    chk("pre_rst_data", 32'(bus.out_data), 32'h210);
    chk("pre_rst_busy", 32'(busy), 1);
    chk("pre_rst_nz", 32'(nz_count), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("post_rst_valid", 32'(bus.out_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_nz", 32'(nz_count), 0);
    chk("post_rst_ovf", 32'(overflow), 0);
    bus.out_ready = 1'b1;

    exp_q.push_back(12'h0A0);
    exp_q.push_back(12'h000);
    send(8'h0A, 1, 1, 0);
    drain();
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
